// File: rtl/srp16_pkg.sv
// srp16_pkg: shared encodings and types for the SRP16 memory arbiter.
package srp16_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic ARB_CPU = 1'b0;
    localparam logic ARB_DMA = 1'b1;
    localparam int   STREAK_W = 4;

    typedef struct packed {
        logic        we;
        logic        word;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;
endpackage

// File: rtl/srp16_mem_arbiter_if.sv
// srp16_mem_arbiter_if: one requester port of the arbiter (CPU or DMA).
interface srp16_mem_arbiter_if;
    logic        req;
    logic        we;
    logic        word;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] rdata;

    modport master (output req, we, word, addr, wdata, input ack, rdata);
    modport slave  (input req, we, word, addr, wdata, output ack, rdata);
endinterface

// File: rtl/srp16_arb_pick.sv
// srp16_arb_pick: CPU-priority pick with a DMA anti-starvation streak counter.
module srp16_arb_pick
    import srp16_pkg::*;
#(
    parameter int CPU_BURST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic cpu_req,
    input  logic dma_req,
    input  logic lock,
    output logic grant,
    output logic pick_dma
);
    localparam logic [STREAK_W-1:0] BURST = STREAK_W'(CPU_BURST);

    logic [STREAK_W-1:0] streak;
    logic                dma_vis;

    // A held lock hides the DMA request and freezes the streak.
    always_comb begin
        dma_vis  = dma_req & ~lock;
        grant    = en & (cpu_req | dma_vis);
        pick_dma = dma_vis & (~cpu_req | (streak >= BURST));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            streak <= '0;
        else if (grant & ~lock)
            streak <= (pick_dma | ~dma_req) ? '0 : ((&streak) ? streak : streak + 1'b1);
    end
endmodule

// File: rtl/srp16_mem_arbiter.sv
// srp16_mem_arbiter: shares a byte-wide memory between CPU and DMA, splitting words into two byte accesses.
// Optional SRP16_MEM_ARB_LOCK_EN adds cpu_lock for atomic CPU read-modify-write sequences.
module srp16_mem_arbiter
    import srp16_pkg::*;
#(
    parameter int CPU_BURST = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    srp16_mem_arbiter_if.slave          cpu,
    srp16_mem_arbiter_if.slave          dma,
`ifdef SRP16_MEM_ARB_LOCK_EN
    input  logic                        cpu_lock,
`endif
    output logic [15:0]                 mem_addr,
    output logic                        mem_rd,
    output logic                        mem_wr,
    output logic [7:0]                  mem_wdata,
    input  logic [7:0]                  mem_rdata,
    output logic                        busy,
    output logic                        gnt_dma
);
    state_t      state, state_nx;
    req_t        cur, sel;
    logic        owner;
    logic [7:0]  lo;
    logic [15:0] cpu_rd_q, dma_rd_q, fin;
    logic        grant, pick_dma, lock_eff, acc, hi, resp;

`ifdef SRP16_MEM_ARB_LOCK_EN
    logic lock_q;
    assign lock_eff = lock_q & cpu_lock;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lock_q <= 1'b0;
        else if (cpu.ack & cpu_lock)
            lock_q <= 1'b1;
        else if (state == ST_IDLE && !cpu_lock)
            lock_q <= 1'b0;
    end
`else
    assign lock_eff = 1'b0;
`endif

    srp16_arb_pick #(.CPU_BURST(CPU_BURST)) u_pick (
        .clk      (clk),
        .reset    (reset),
        .en       (state == ST_IDLE),
        .cpu_req  (cpu.req),
        .dma_req  (dma.req),
        .lock     (lock_eff),
        .grant    (grant),
        .pick_dma (pick_dma)
    );

    always_comb begin
        sel = pick_dma ? '{dma.we, dma.word, dma.addr, dma.wdata}
                       : '{cpu.we, cpu.word, cpu.addr, cpu.wdata};
        state_nx = state;
        case (state)
            ST_IDLE: state_nx = grant ? ST_ACC0 : ST_IDLE;
            ST_ACC0: state_nx = cur.word ? ST_ACC1 : ST_RESP;
            ST_ACC1: state_nx = ST_RESP;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cur      <= '0;
            owner    <= ARB_CPU;
            lo       <= '0;
            cpu_rd_q <= '0;
            dma_rd_q <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                cur   <= sel;
                owner <= pick_dma ? ARB_DMA : ARB_CPU;
            end
            if (state == ST_ACC1 && !cur.we)
                lo <= mem_rdata;
            if (resp && !cur.we) begin
                if (owner == ARB_DMA)
                    dma_rd_q <= fin;
                else
                    cpu_rd_q <= fin;
            end
        end
    end

    // Final byte arrives in RESP; present it combinationally so rdata is valid with ack.
    always_comb begin
        acc       = (state == ST_ACC0) || (state == ST_ACC1);
        hi        = (state == ST_ACC1);
        resp      = (state == ST_RESP);
        fin       = cur.word ? {mem_rdata, lo} : {8'h00, mem_rdata};
        mem_addr  = acc ? cur.addr + {15'b0, hi} : 16'h0000;
        mem_rd    = acc & ~cur.we;
        mem_wr    = acc & cur.we;
        mem_wdata = acc ? (hi ? cur.wdata[15:8] : cur.wdata[7:0]) : 8'h00;
        busy      = (state != ST_IDLE);
        gnt_dma   = owner;
        cpu.ack   = resp & (owner == ARB_CPU);
        dma.ack   = resp & (owner == ARB_DMA);
        cpu.rdata = (cpu.ack & ~cur.we) ? fin : cpu_rd_q;
        dma.rdata = (dma.ack & ~cur.we) ? fin : dma_rd_q;
    end
endmodule

// File: tb/tb_srp16_mem_arbiter.sv
// tb_srp16_mem_arbiter: directed checks of the SRP16 memory arbiter against a byte memory model.
module tb_srp16_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] mem_addr, mem_addr0;
    logic        mem_rd, mem_wr, mem_rd0, mem_wr0;
    logic [7:0]  mem_wdata, mem_wdata0;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  mem_rdata0 = 8'h00;
    logic        busy, gnt_dma, busy0, gnt_dma0;
    logic [7:0]  mem [0:65535];
    logic        tb_we = 1'b0;
    logic [15:0] tb_a = 16'h0;
    logic [7:0]  tb_d = 8'h0;
    logic [24:0] log_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
`ifdef SRP16_MEM_ARB_LOCK_EN
    logic        cpu_lock = 1'b0;
    logic        cpu_lock0 = 1'b0;
`endif

    srp16_mem_arbiter_if cpu_if ();
    srp16_mem_arbiter_if dma_if ();
    srp16_mem_arbiter_if c0_if ();
    srp16_mem_arbiter_if d0_if ();

    always #5 clk = ~clk;

    srp16_mem_arbiter #(.CPU_BURST(4)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .cpu       (cpu_if),
        .dma       (dma_if),
`ifdef SRP16_MEM_ARB_LOCK_EN
        .cpu_lock  (cpu_lock),
`endif
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .gnt_dma   (gnt_dma)
    );

    srp16_mem_arbiter #(.CPU_BURST(0)) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .cpu       (c0_if),
        .dma       (d0_if),
`ifdef SRP16_MEM_ARB_LOCK_EN
        .cpu_lock  (cpu_lock0),
`endif
        .mem_addr  (mem_addr0),
        .mem_rd    (mem_rd0),
        .mem_wr    (mem_wr0),
        .mem_wdata (mem_wdata0),
        .mem_rdata (mem_rdata0),
        .busy      (busy0),
        .gnt_dma   (gnt_dma0)
    );

    // Synchronous byte memory with a bench preload port and an access log.
    always @(posedge clk) begin
        if (tb_we)
            mem[tb_a] <= tb_d;
        else if (mem_wr)
            mem[mem_addr] <= mem_wdata;
        if (mem_rd)
            mem_rdata <= mem[mem_addr];
        if (mem_rd | mem_wr)
            log_q.push_back({mem_wr, mem_addr, mem_wdata});
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we = 1'b1;
        tb_a  = a;
        tb_d  = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // One transaction on a port; lat counts cycles from the req cycle to the ack cycle inclusive.
    task automatic xact(input logic d, input logic we, input logic word, input logic [15:0] addr,
                        input logic [15:0] wdata, output int lat, output logic [15:0] rd);
        logic ack;
        @(negedge clk);
        if (d) begin
            dma_if.we = we; dma_if.word = word; dma_if.addr = addr; dma_if.wdata = wdata; dma_if.req = 1'b1;
        end else begin
            cpu_if.we = we; cpu_if.word = word; cpu_if.addr = addr; cpu_if.wdata = wdata; cpu_if.req = 1'b1;
        end
        lat = 1;
        rd  = 16'h0;
        ack = 1'b0;
        while (!ack && lat < 20) begin
            @(negedge clk);
            lat++;
            ack = d ? dma_if.ack : cpu_if.ack;
        end
        if (!ack)
            check("ack_timeout", 32'(lat), 32'd0);
        rd = d ? dma_if.rdata : cpu_if.rdata;
        if (d) dma_if.req = 1'b0;
        else   cpu_if.req = 1'b0;
    endtask

    task automatic wait_ack(output logic d, output logic ok);
        int n;
        n  = 0;
        ok = 1'b0;
        d  = 1'b0;
        while (!ok && n < 20) begin
            @(negedge clk);
            n++;
            ok = cpu_if.ack | dma_if.ack;
            d  = dma_if.ack;
        end
        if (!ok)
            check("grant_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        int          lat, base;
        logic [15:0] rd;
        logic [9:0]  seq;
        logic        d, ok;
        cpu_if.req = 0; cpu_if.we = 0; cpu_if.word = 0; cpu_if.addr = 0; cpu_if.wdata = 0;
        dma_if.req = 0; dma_if.we = 0; dma_if.word = 0; dma_if.addr = 0; dma_if.wdata = 0;
        c0_if.req = 0;  c0_if.we = 0;  c0_if.word = 0;  c0_if.addr = 0;  c0_if.wdata = 0;
        d0_if.req = 0;  d0_if.we = 0;  d0_if.word = 0;  d0_if.addr = 0;  d0_if.wdata = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_mem_rd_wr", {mem_rd, mem_wr}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_ack", {cpu_if.ack, dma_if.ack}, 0);
        check("rst_rdata", {cpu_if.rdata, dma_if.rdata}, 0);
        check("rst_gnt_dma", gnt_dma, 0);
        reset = 1'b1;
        poke(16'h0010, 8'h34);
        poke(16'h0011, 8'h12);
        poke(16'h0021, 8'hAA);
        poke(16'h0030, 8'h7F);
        poke(16'h0040, 8'hCD);
        poke(16'h0041, 8'hAB);

        // CPU word read
        base = log_q.size();
        xact(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, lat, rd);
        check("t1_lat", lat, 4);
        check("t1_rdata", rd, 16'h1234);
        check("t1_nacc", log_q.size() - base, 2);
        check("t1_acc0", log_q[base], {1'b0, 16'h0010, 8'h00});
        check("t1_acc1", log_q[base+1], {1'b0, 16'h0011, 8'h00});

        // DMA byte and word writes at the top of memory
        base = log_q.size();
        xact(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'hAB55, lat, rd);
        check("t2_lat", lat, 3);
        check("t2_nacc", log_q.size() - base, 1);
        check("t2_acc", log_q[base], {1'b1, 16'hFFFF, 8'h55});
        check("t2_mem", mem[16'hFFFF], 8'h55);
        base = log_q.size();
        xact(1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hBEEF, lat, rd);
        @(negedge clk);
        check("t2w_lat", lat, 4);
        check("t2w_acc1", log_q[base+1], {1'b1, 16'h0000, 8'hBE});
        check("t2w_lo", mem[16'hFFFF], 8'hEF);
        check("t2w_hi", mem[16'h0000], 8'hBE);

        // CPU byte read, then DMA word read leaves cpu_rdata alone
        xact(1'b0, 1'b0, 1'b0, 16'h0030, 16'h0000, lat, rd);
        check("t5_lat", lat, 3);
        check("t5_cpu_rdata", rd, 16'h007F);
        xact(1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, lat, rd);
        check("t5_dma_rdata", rd, 16'hABCD);
        check("t5_gnt_dma", gnt_dma, 1);
        check("t5_cpu_hold", cpu_if.rdata, 16'h007F);
        @(negedge clk);
        check("t5_cpu_hold2", cpu_if.rdata, 16'h007F);

        // Both ports held high, CPU_BURST = 4
        @(negedge clk);
        cpu_if.we = 0; cpu_if.word = 0; cpu_if.addr = 16'h0030; cpu_if.req = 1;
        dma_if.we = 0; dma_if.word = 0; dma_if.addr = 16'h0030; dma_if.req = 1;
        seq = '0;
        for (int i = 0; i < 10; i++) begin
            wait_ack(d, ok);
            seq = {seq[8:0], d};
        end
        cpu_if.req = 0;
        dma_if.req = 0;
        check("t3_order", seq, 10'b0000100001);

        // CPU_BURST = 0: DMA wins the tie, CPU follows
        @(negedge clk);
        c0_if.req = 1;
        d0_if.req = 1;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = c0_if.ack | d0_if.ack;
        end
        check("t3b_first_dma", {ok, d0_if.ack}, 2'b11);
        d0_if.req = 0;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = c0_if.ack | d0_if.ack;
        end
        check("t3b_then_cpu", {ok, c0_if.ack}, 2'b11);
        c0_if.req = 0;

        // Reset during ACC1 of a word write
        @(negedge clk);
        @(negedge clk);
        cpu_if.we = 1; cpu_if.word = 1; cpu_if.addr = 16'h0020; cpu_if.wdata = 16'h1234; cpu_if.req = 1;
        @(negedge clk);
        check("t4_acc0", {mem_wr, mem_addr, mem_wdata}, {1'b1, 16'h0020, 8'h34});
        @(negedge clk);
        check("t4_acc1", {mem_wr, mem_addr, mem_wdata}, {1'b1, 16'h0021, 8'h12});
        reset = 1'b0;
        #1;
        check("t4_rst_out", {busy, mem_wr, mem_rd, mem_addr, mem_wdata, cpu_if.ack}, 0);
        cpu_if.req = 0;
        @(negedge clk);
        check("t4_no_ack", cpu_if.ack, 0);
        check("t4_lo", mem[16'h0020], 8'h34);
        check("t4_hi", mem[16'h0021], 8'hAA);
        reset = 1'b1;
        xact(1'b0, 1'b0, 1'b1, 16'h0020, 16'h0000, lat, rd);
        check("t4_after_lat", lat, 4);
        check("t4_after_rd", rd, 16'hAA34);

`ifdef SRP16_MEM_ARB_LOCK_EN
        // Lock keeps DMA out across two CPU writes
        @(negedge clk);
        cpu_lock = 1;
        dma_if.we = 0; dma_if.word = 0; dma_if.addr = 16'h0030; dma_if.req = 1;
        xact(1'b0, 1'b1, 1'b0, 16'h0050, 16'h0011, lat, rd);
        check("t6_first_cpu", gnt_dma, 0);
        repeat (3) begin
            @(negedge clk);
            check("t6_locked_idle", busy, 0);
        end
        xact(1'b0, 1'b1, 1'b0, 16'h0051, 16'h0022, lat, rd);
        check("t6_second_cpu", gnt_dma, 0);
        @(negedge clk);
        check("t6_still_locked", busy, 0);
        cpu_lock = 0;
        @(negedge clk);
        check("t6_dma_granted", {busy, gnt_dma}, 2'b11);
        wait_ack(d, ok);
        dma_if.req = 0;
        check("t6_dma_ack", {ok, d}, 2'b11);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
